// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the M stage: FSM encoding, alignment mask
// and the W pipeline register payload.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } w_bundle_t;

  localparam w_bundle_t W_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_if.sv
// Data memory request/acknowledge bus between the M stage and the data memory.
interface memory_stage_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/memory_stage_writeback_reg.sv
// W pipeline register: loads the M-stage result every cycle, or an all-zero
// bubble when the M stage has nothing valid to hand on.
module writeback_reg
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      bubble,
  input  w_bundle_t d,
  output w_bundle_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= W_BUBBLE;
    end else if (bubble) begin
      q <= W_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// M stage of the pipelined MIPS core: word loads/stores over a req/ack bus,
// stalls while an access is outstanding and aborts accesses that time out.
//
// state | meaning
// IDLE  | no access outstanding; a new aligned access is issued straight from the M inputs
// BUSY  | access outstanding; bus driven from latched address/data, waiting for ack or timeout
module memory_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_write_m_i,
  input  logic                  mem_write_m_i,
  input  logic                  mem_to_reg_m_i,
  input  logic [31:0]           alu_out_m_i,
  input  logic [31:0]           write_data_m_i,
  input  logic [4:0]            write_reg_m_i,
  memory_stage_if.master        dmem,
  output logic                  stall_o,
  output logic                  bus_err_o,
  output logic                  reg_write_w_o,
  output logic                  mem_to_reg_w_o,
  output logic [31:0]           read_data_w_o,
  output logic [31:0]           alu_out_w_o,
  output logic [4:0]            write_reg_w_o
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op, misaligned;
  logic        req_c, stall_c, we_c;
  logic [31:0] addr_c, wdata_c;
  logic        w_bubble;
  w_bundle_t   w_d, w_q;

  assign mem_op     = mem_write_m_i | mem_to_reg_m_i;
  assign misaligned = |(alu_out_m_i[1:0] & WORD_ALIGN_MASK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    bus_err_d = 1'b0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    w_bubble  = 1'b1;
    // A store with mem_to_reg also set is treated as a plain store.
    w_d.reg_write  = reg_write_m_i;
    w_d.mem_to_reg = mem_to_reg_m_i & ~mem_write_m_i;
    w_d.read_data  = '0;
    w_d.alu_out    = alu_out_m_i;
    w_d.write_reg  = write_reg_m_i;

    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          w_bubble = 1'b0;
        end else if (misaligned) begin
          bus_err_d = 1'b1;
        end else begin
          req_c   = 1'b1;
          we_c    = mem_write_m_i;
          addr_c  = alu_out_m_i;
          wdata_c = write_data_m_i;
          if (dmem.ack) begin
            w_bubble      = 1'b0;
            w_d.read_data = mem_write_m_i ? 32'h0 : dmem.rdata;
          end else begin
            stall_c = 1'b1;
            addr_d  = alu_out_m_i;
            wdata_d = write_data_m_i;
            we_d    = mem_write_m_i;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        we_c    = we_q;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        if (dmem.ack) begin
          w_bubble      = 1'b0;
          w_d.read_data = we_q ? 32'h0 : dmem.rdata;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LIMIT) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated with reset so req/stall drop the moment reset asserts, even while
  // the M inputs still present a memory op.
  assign dmem.req   = req_c & rst_ni;
  assign dmem.we    = we_c;
  assign dmem.addr  = addr_c;
  assign dmem.wdata = wdata_c;
  assign stall_o    = stall_c & rst_ni;
  assign bus_err_o  = bus_err_q;

  writeback_reg u_writeback_reg (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .bubble (w_bubble),
    .d      (w_d),
    .q      (w_q)
  );

  assign reg_write_w_o  = w_q.reg_write;
  assign mem_to_reg_w_o = w_q.mem_to_reg;
  assign read_data_w_o  = w_q.read_data;
  assign alu_out_w_o    = w_q.alu_out;
  assign write_reg_w_o  = w_q.write_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with TIMEOUT=4: zero-wait store, wait-state
// load, misaligned access, timeout abort, ack at the limit and mid-access reset.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        reg_write_m, mem_write_m, mem_to_reg_m;
  logic [31:0] alu_out_m, write_data_m;
  logic [4:0]  write_reg_m;
  logic        stall, bus_err;
  logic        reg_write_w, mem_to_reg_w;
  logic [31:0] read_data_w, alu_out_w;
  logic [4:0]  write_reg_w;

  int n_checks = 0;
  int n_errors = 0;

  memory_stage_if dmem_bus ();

  memory_stage #(.TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .reg_write_m_i  (reg_write_m),
    .mem_write_m_i  (mem_write_m),
    .mem_to_reg_m_i (mem_to_reg_m),
    .alu_out_m_i    (alu_out_m),
    .write_data_m_i (write_data_m),
    .write_reg_m_i  (write_reg_m),
    .dmem           (dmem_bus.master),
    .stall_o        (stall),
    .bus_err_o      (bus_err),
    .reg_write_w_o  (reg_write_w),
    .mem_to_reg_w_o (mem_to_reg_w),
    .read_data_w_o  (read_data_w),
    .alu_out_w_o    (alu_out_w),
    .write_reg_w_o  (write_reg_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic mtr,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    reg_write_m  = rw;
    mem_write_m  = mw;
    mem_to_reg_m = mtr;
    alu_out_m    = alu;
    write_data_m = wd;
    write_reg_m  = wr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cnt;
    int stall_cnt;
    bit done;

    rst_ni = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    #2;
    check("rst_req", 32'(dmem_bus.req), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    check("rst_w_alu", alu_out_w, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();

    // non-memory op with a stray ack: W takes the ALU result, read data stays 0
    set_m(1'b1, 1'b0, 1'b0, 32'h1234_5679, 32'h0, 5'd10);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("alu_req", 32'(dmem_bus.req), 32'h0);
    check("alu_stall", 32'(stall), 32'h0);
    next_cycle();
    check("alu_w_alu", alu_out_w, 32'h1234_5679);
    check("alu_w_rd", read_data_w, 32'h0);
    check("alu_w_reg", 32'(write_reg_w), 32'd10);
    check("alu_err", 32'(bus_err), 32'h0);

    // zero-wait store
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'h5555_5555;
    @(negedge clk);
    check("st_req", 32'(dmem_bus.req), 32'h1);
    check("st_we", 32'(dmem_bus.we), 32'h1);
    check("st_addr", dmem_bus.addr, 32'h10);
    check("st_wdata", dmem_bus.wdata, 32'hDEAD_BEEF);
    check("st_stall", 32'(stall), 32'h0);
    next_cycle();
    dmem_bus.ack = 1'b0;
    check("st_w_rw", 32'(reg_write_w), 32'h0);
    check("st_w_rd", read_data_w, 32'h0);
    check("st_w_alu", alu_out_w, 32'h10);

    // load with 3 wait cycles: ack in the 4th request cycle
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 5'd8);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'h1234_5678;
      end
      @(negedge clk);
      check("ld_req", 32'(dmem_bus.req), 32'h1);
      check("ld_we", 32'(dmem_bus.we), 32'h0);
      if (stall) stall_cnt++;
      next_cycle();
    end
    dmem_bus.ack = 1'b0;
    check("ld_stall_cycles", 32'(stall_cnt), 32'd3);
    check("ld_w_rd", read_data_w, 32'h1234_5678);
    check("ld_w_reg", 32'(write_reg_w), 32'd8);
    check("ld_w_mtr", 32'(mem_to_reg_w), 32'h1);
    check("ld_w_rw", 32'(reg_write_w), 32'h1);

    // misaligned load
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 5'd9);
    @(negedge clk);
    check("mis_req", 32'(dmem_bus.req), 32'h0);
    check("mis_stall", 32'(stall), 32'h0);
    next_cycle();
    check("mis_err", 32'(bus_err), 32'h1);
    check("mis_w_rw", 32'(reg_write_w), 32'h0);
    check("mis_w_alu", alu_out_w, 32'h0);
    check("mis_w_reg", 32'(write_reg_w), 32'h0);
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    next_cycle();
    check("mis_err_pulse", 32'(bus_err), 32'h0);

    // timeout: issue cycle plus 4 BUSY cycles, last one aborts with stall low
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd3);
    req_cnt = 0;
    stall_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (dmem_bus.req) req_cnt++;
      if (stall) stall_cnt++;
      check("to_addr", dmem_bus.addr, 32'h40);
      if (dmem_bus.req && !stall) done = 1'b1;
      next_cycle();
      if (c == 0) alu_out_m = 32'h0000_0080;
    end
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("to_req_cycles", 32'(req_cnt), 32'd5);
    check("to_stall_cycles", 32'(stall_cnt), 32'd4);
    check("to_err", 32'(bus_err), 32'h1);
    check("to_w_rw", 32'(reg_write_w), 32'h0);
    @(negedge clk);
    check("to_idle_req", 32'(dmem_bus.req), 32'h0);
    check("to_idle_stall", 32'(stall), 32'h0);
    next_cycle();
    check("to_err_pulse", 32'(bus_err), 32'h0);

    // ack in the timeout-limit cycle wins
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 5'd5);
    stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'hCAFE_F00D;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      next_cycle();
    end
    dmem_bus.ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("lim_stall_cycles", 32'(stall_cnt), 32'd4);
    check("lim_err", 32'(bus_err), 32'h0);
    check("lim_w_rd", read_data_w, 32'hCAFE_F00D);
    check("lim_w_reg", 32'(write_reg_w), 32'd5);

    // reset during BUSY cycle 2
    next_cycle();
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0060, 32'h0, 5'd7);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rb_req_before", 32'(dmem_bus.req), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("rb_req", 32'(dmem_bus.req), 32'h0);
    check("rb_stall", 32'(stall), 32'h0);
    check("rb_w_rw", 32'(reg_write_w), 32'h0);
    check("rb_w_alu", alu_out_w, 32'h0);
    check("rb_err", 32'(bus_err), 32'h0);
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();

    // fresh access after reset, zero wait
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0070, 32'h0, 5'd9);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("ar_req", 32'(dmem_bus.req), 32'h1);
    check("ar_addr", dmem_bus.addr, 32'h70);
    check("ar_stall", 32'(stall), 32'h0);
    next_cycle();
    dmem_bus.ack = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("ar_w_rd", read_data_w, 32'h0BAD_F00D);
    check("ar_w_reg", 32'(write_reg_w), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
